// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and EX/MEM, MEM/WB
// operand forwarding onto the ALU operands and store data.

module id_ex_fwd #(
  parameter int FWD_EN = 1
) (
  input  logic [4:0]  rs,
  input  logic [31:0] rs_data,
  input  logic        exmem_regwrite,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_regwrite,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_data,
  output logic [31:0] fwd_data
);
  logic ex_hit, wb_hit;

  // x0 is hardwired zero, so a producer targeting it never forwards
  assign ex_hit = (FWD_EN != 0) && exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rs);
  assign wb_hit = (FWD_EN != 0) && memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rs);

  always_comb begin
    fwd_data = rs_data;
    if (ex_hit)      fwd_data = exmem_result;
    else if (wb_hit) fwd_data = memwb_data;
  end
endmodule

module id_ex_stage #(
  parameter int FWD_EN = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        in_valid,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  input  logic [31:0] in_imm,
  input  logic [3:0]  in_alu_ctrl,
  input  logic        in_alusrc,
  input  logic        in_regwrite,
  input  logic        in_memread,
  input  logic        in_memwrite,
  input  logic        in_memtoreg,
  input  logic        exmem_regwrite,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_regwrite,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_data,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [3:0]  Control_in,
  output logic        ex_valid,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_memtoreg,
  output logic [4:0]  ex_rd,
  output logic [31:0] ex_store_data,
  output logic        hazard_stall
);
  typedef struct packed {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_data, rs2_data, imm;
    logic [3:0]  alu_ctrl;
    logic        alusrc, regwrite, memread, memwrite, memtoreg;
  } idex_t;

  idex_t r, dec;

  assign dec = '{valid: in_valid, rs1: in_rs1, rs2: in_rs2, rd: in_rd,
                 rs1_data: in_rs1_data, rs2_data: in_rs2_data, imm: in_imm,
                 alu_ctrl: in_alu_ctrl, alusrc: in_alusrc, regwrite: in_regwrite,
                 memread: in_memread, memwrite: in_memwrite, memtoreg: in_memtoreg};

  // Load in EX whose destination the decoding instruction reads
  assign hazard_stall = ex_valid && ex_memread && (r.rd != 5'd0) && in_valid &&
                        ((r.rd == in_rs1) || (r.rd == in_rs2));

  // A bubble is the all-zero register image
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          r <= '0;
    else if (flush_in)     r <= '0;
    else if (stall_in)     r <= r;
    else if (hazard_stall) r <= '0;
    else                   r <= dec;
  end

  logic [1:0][4:0]  op_rs;
  logic [1:0][31:0] op_data, op_fwd;

  assign op_rs   = {r.rs2, r.rs1};
  assign op_data = {r.rs2_data, r.rs1_data};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    id_ex_fwd #(.FWD_EN(FWD_EN)) u_fwd (
      .rs(op_rs[g]), .rs_data(op_data[g]),
      .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
      .fwd_data(op_fwd[g])
    );
  end

  assign A             = op_fwd[0];
  assign B             = r.alusrc ? r.imm : op_fwd[1];
  assign ex_store_data = op_fwd[1];
  assign Control_in    = r.alu_ctrl;
  assign ex_valid      = r.valid;
  assign ex_regwrite   = r.regwrite & r.valid;
  assign ex_memread    = r.memread  & r.valid;
  assign ex_memwrite   = r.memwrite & r.valid;
  assign ex_memtoreg   = r.memtoreg & r.valid;
  assign ex_rd         = r.rd;
endmodule
